// File: rtl/led_ctrl_pkg.sv
// Shared LED-control definitions: debounce FSM encoding and default timing constants.
// Defaults give 1 ms of required stability at a 50 MHz system clock.
package led_ctrl_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int CNT_W_DEF           = 16;

  typedef enum logic [1:0] {
    S_LOW       = 2'b00,
    S_WAIT_HIGH = 2'b01,
    S_HIGH      = 2'b10,
    S_WAIT_LOW  = 2'b11
  } db_state_t;

  // A WAIT_LOW state still presents the previously accepted high level.
  function automatic logic is_high_level(input db_state_t s);
    return (s == S_HIGH) || (s == S_WAIT_LOW);
  endfunction

endpackage

// File: rtl/switch_debounce_checker.sv
// Runtime invariants of the debounce FSM and its output pulses.
// Observes only; drives nothing back into the design.
module switch_debounce_checker
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int TOGGLE_MODE     = 0
) (
  input logic             sysclk,
  input logic             rst_n,
  input db_state_t        state,
  input logic [CNT_W-1:0] cnt,
  input logic             enable,
  input logic             rise,
  input logic             fall
);

  localparam logic [CNT_W:0] CNT_LIMIT = (CNT_W+1)'(DEBOUNCE_CYCLES);

  a_rise_fall_excl: assert property (@(posedge sysclk) disable iff (!rst_n)
    !(rise && fall)) else $error("rise and fall asserted together");

  a_rise_single: assert property (@(posedge sysclk) disable iff (!rst_n)
    rise |=> !rise) else $error("rise wider than one cycle");

  a_fall_single: assert property (@(posedge sysclk) disable iff (!rst_n)
    fall |=> !fall) else $error("fall wider than one cycle");

  a_cnt_bound: assert property (@(posedge sysclk) disable iff (!rst_n)
    {1'b0, cnt} < CNT_LIMIT) else $error("debounce counter out of range");

  a_enable_on_pulse: assert property (@(posedge sysclk) disable iff (!rst_n)
    (enable != $past(enable)) |-> (rise || fall)) else $error("enable moved without a pulse");

  generate
    if (TOGGLE_MODE == 0) begin : g_level
      a_level_map: assert property (@(posedge sysclk) disable iff (!rst_n)
        enable == is_high_level(state)) else $error("enable disagrees with stable level");
    end
    if (DEBOUNCE_CYCLES == 1) begin : g_no_wait
      a_no_wait: assert property (@(posedge sysclk) disable iff (!rst_n)
        (state == S_LOW) || (state == S_HIGH)) else $error("wait state visited");
    end
  endgenerate

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all zeros.
// Reusable for any switch or strap input crossing into the sysclk domain.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;

  // First flop may go metastable; only the second flop is consumed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {W{1'b0}};
      q      <= {W{1'b0}};
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Debounces a raw slide switch / push button into a clean Enable level plus
// one-cycle Rise/Fall pulses; optional toggle mode flips Enable on each press.
module switch_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int TOGGLE_MODE     = 0
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic SW_raw,
  output logic Enable,
  output logic Rise,
  output logic Fall
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               SKIP_WAIT = (DEBOUNCE_CYCLES == 1);
  localparam bit               TOGGLE    = (TOGGLE_MODE != 0);

  logic             sw_s;
  db_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;

  sync_2ff #(.W(1)) u_sync (
    .clk   (sysclk),
    .rst_n (rst_n),
    .d     (SW_raw),
    .q     (sw_s)
  );

  // Debounce FSM with registered Enable/Rise/Fall; the counter holds the
  // number of consecutive differing edges seen so far and never reaches the limit.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_LOW;
      cnt_r   <= CNT_ZERO;
      Enable  <= 1'b0;
      Rise    <= 1'b0;
      Fall    <= 1'b0;
    end else begin
      Rise <= 1'b0;
      Fall <= 1'b0;
      case (state_r)
        S_LOW: begin
          cnt_r <= CNT_ZERO;
          if (sw_s) begin
            if (SKIP_WAIT) begin
              state_r <= S_HIGH;
              Rise    <= 1'b1;
              Enable  <= TOGGLE ? ~Enable : 1'b1;
            end else begin
              state_r <= S_WAIT_HIGH;
              cnt_r   <= CNT_ONE;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (!sw_s) begin
            state_r <= S_LOW;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= S_HIGH;
            cnt_r   <= CNT_ZERO;
            Rise    <= 1'b1;
            Enable  <= TOGGLE ? ~Enable : 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_HIGH: begin
          cnt_r <= CNT_ZERO;
          if (!sw_s) begin
            if (SKIP_WAIT) begin
              state_r <= S_LOW;
              Fall    <= 1'b1;
              Enable  <= TOGGLE ? Enable : 1'b0;
            end else begin
              state_r <= S_WAIT_LOW;
              cnt_r   <= CNT_ONE;
            end
          end
        end
        S_WAIT_LOW: begin
          if (sw_s) begin
            state_r <= S_HIGH;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= S_LOW;
            cnt_r   <= CNT_ZERO;
            Fall    <= 1'b1;
            Enable  <= TOGGLE ? Enable : 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= S_LOW;
          cnt_r   <= CNT_ZERO;
          Enable  <= 1'b0;
        end
      endcase
    end
  end

  switch_debounce_checker #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .TOGGLE_MODE     (TOGGLE_MODE)
  ) u_chk (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .state  (state_r),
    .cnt    (cnt_r),
    .enable (Enable),
    .rise   (Rise),
    .fall   (Fall)
  );

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce: three instances (level D=4, toggle D=4,
// level D=1); expected pulses are queued at stimulus time and matched by a monitor.
module tb_switch_debounce;

  typedef struct {
    int id;
    bit is_rise;
    bit en;
    int at;
  } ev_t;

  logic       sysclk;
  logic       rst_n;
  logic [2:0] sw;
  logic [2:0] en;
  logic [2:0] rise;
  logic [2:0] fall;
  logic [2:0] prev_en;
  int         cyc;
  int         total;
  int         bad;
  ev_t        sbq[$];
  ev_t        e;

  switch_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(16), .TOGGLE_MODE(0)) u_lvl (
    .sysclk(sysclk), .rst_n(rst_n), .SW_raw(sw[0]), .Enable(en[0]), .Rise(rise[0]), .Fall(fall[0]));
  switch_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(8), .TOGGLE_MODE(1)) u_tgl (
    .sysclk(sysclk), .rst_n(rst_n), .SW_raw(sw[1]), .Enable(en[1]), .Rise(rise[1]), .Fall(fall[1]));
  switch_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(4), .TOGGLE_MODE(0)) u_d1 (
    .sysclk(sysclk), .rst_n(rst_n), .SW_raw(sw[2]), .Enable(en[2]), .Rise(rise[2]), .Fall(fall[2]));

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Queue an expected pulse `lat` edges after the edge that follows now.
  task automatic expect_ev(input int id, input bit is_rise, input bit en_v, input int lat);
    ev_t x;
    x.id = id; x.is_rise = is_rise; x.en = en_v; x.at = cyc + lat;
    sbq.push_back(x);
  endtask

  // Monitor: match every pulse against the scoreboard, and flag Enable moving silently.
  always @(negedge sysclk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        prev_en[i] = en[i];
      end else begin
        if (rise[i] || fall[i]) begin
          check("rise_fall_excl", int'(rise[i] & fall[i]), 0);
          if (sbq.size() == 0) begin
            check("unexpected_pulse", int'(rise[i] | fall[i]), 0);
          end else begin
            e = sbq.pop_front();
            check("ev_id", i, e.id);
            check("ev_kind_rise", int'(rise[i]), int'(e.is_rise));
            check("ev_cycle", cyc, e.at);
            check("ev_enable", int'(en[i]), int'(e.en));
          end
        end else begin
          check("enable_without_pulse", int'(en[i]), int'(prev_en[i]));
        end
        prev_en[i] = en[i];
      end
    end
  end

  initial begin
    logic [5:0] pat;
    total = 0;
    bad   = 0;
    sw    = 3'b000;
    rst_n = 1'b0;
    prev_en = 3'b000;
    step(3);
    check("reset_enable", int'(en), 0);
    check("reset_rise", int'(rise), 0);
    check("reset_fall", int'(fall), 0);
    rst_n = 1'b1;
    step(2);

    // Clean press and release, D=4: outputs 5 edges after first sample.
    sw[0] = 1'b1; expect_ev(0, 1'b1, 1'b1, 6);
    step(12);
    check("press_level", int'(en[0]), 1);
    sw[0] = 1'b0; expect_ev(0, 1'b0, 1'b0, 6);
    step(12);
    check("release_level", int'(en[0]), 0);

    // Glitch of 3 cycles must vanish.
    sw[0] = 1'b1;
    step(3);
    sw[0] = 1'b0;
    step(15);
    check("glitch_level", int'(en[0]), 0);

    // Bounce 1,0,1,1,0,1 then held high: one Rise after the final 0->1.
    pat = 6'b101101;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step(1);
      sw[0] = pat[5-k];
    end
    expect_ev(0, 1'b1, 1'b1, 6);
    step(14);
    check("bounce_level", int'(en[0]), 1);
    sw[0] = 1'b0; expect_ev(0, 1'b0, 1'b0, 6);
    step(12);

    // Toggle mode: Enable goes 1,0,1 on successive presses; release leaves it alone.
    for (int r = 0; r < 3; r++) begin
      sw[1] = 1'b1; expect_ev(1, 1'b1, (r != 1), 6);
      step(10);
      sw[1] = 1'b0; expect_ev(1, 1'b0, (r != 1), 6);
      step(10);
    end
    check("toggle_final", int'(en[1]), 1);

    // Reset at count 2 discards the pending press; full latency after release.
    sw[0] = 1'b1;
    step(4);
    rst_n = 1'b0;
    step(1);
    check("midreset_enable", int'(en), 0);
    check("midreset_pulses", int'(rise | fall), 0);
    step(2);
    rst_n = 1'b1;
    expect_ev(0, 1'b1, 1'b1, 6);
    step(12);
    check("post_reset_level", int'(en[0]), 1);
    sw[0] = 1'b0; expect_ev(0, 1'b0, 1'b0, 6);
    step(12);

    // D=1: every held change lands at edge 2.
    for (int r = 0; r < 2; r++) begin
      sw[2] = 1'b1; expect_ev(2, 1'b1, 1'b1, 3);
      step(6);
      check("d1_high", int'(en[2]), 1);
      sw[2] = 1'b0; expect_ev(2, 1'b0, 1'b0, 3);
      step(6);
      check("d1_low", int'(en[2]), 0);
    end

    step(5);
    check("sb_pending", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the number of consecutive clock edges a changed input must persist before it is accepted (1 ms at 50 MHz); legal range 1..2^CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the debounce counter width.
REQ-003 SHALL have parameter TOGGLE_MODE, default 0, where 0 means Enable follows the switch level and 1 means each debounced press toggles Enable.
REQ-004 SHALL have port sysclk  input  1  the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port SW_raw  input  1  the raw, asynchronous, bouncing slide switch or push button.
REQ-007 SHALL have port Enable  output  1  the registered clean enable, fed directly to the PWM breathing stage's enable input.
REQ-008 SHALL have port Rise  output  1  a one-cycle pulse on each accepted 0->1 switch transition.
REQ-009 SHALL have port Fall  output  1  a one-cycle pulse on each accepted 1->0 switch transition.

Function
REQ-010 SHALL pass SW_raw through a two-flop synchronizer; the second flop (sw_s) is the only value the debounce logic observes.
REQ-011 SHALL implement a 4-state FSM:
- S_LOW: stable level 0.
- S_WAIT_HIGH: counting while sw_s=1.
- S_HIGH: stable level 1.
- S_WAIT_LOW: counting while sw_s=0.
REQ-012 SHALL move S_LOW->S_WAIT_HIGH (or S_HIGH->S_WAIT_LOW) on the first edge at which sw_s differs from the stable level; the counter is loaded to 1 on that edge.
REQ-013 SHALL, in a WAIT state, increment the counter on each edge at which sw_s still differs from the stable level.
REQ-014 SHALL, in a WAIT state, return to the originating stable state and clear the counter on any edge at which sw_s equals the stable level again (glitch rejected; no output change).
REQ-015 SHALL accept the transition on the DEBOUNCE_CYCLES-th consecutive differing edge: the FSM enters the new stable state and the counter clears on that edge.
REQ-016 SHALL, when DEBOUNCE_CYCLES=1, go directly from one stable state to the other on the first differing edge without visiting the WAIT state.
REQ-017 SHALL never wrap the counter; the comparison against DEBOUNCE_CYCLES bounds it.
REQ-018 SHALL make the accepted transition visible on Enable (level mode), Rise and Fall on the same edge the FSM enters the new stable state; Rise and Fall are high for exactly one cycle and never simultaneously.
REQ-019 SHALL set latency: if SW_raw is first sampled at the new level at edge 0 and then held, the outputs change at edge DEBOUNCE_CYCLES+1.
REQ-020 SHALL, with TOGGLE_MODE=0, drive Enable = 1 in S_HIGH and S_WAIT_LOW, and Enable = 0 otherwise.
REQ-021 SHALL, with TOGGLE_MODE=1, invert Enable on each Rise; Fall does not affect Enable; Rise and Fall still reflect the switch itself.
REQ-022 SHALL ignore any bounce shorter than DEBOUNCE_CYCLES edges completely, including repeated bounce that restarts the count.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force: both synchronizer flops 0, FSM to S_LOW, counter 0, Enable 0, Rise 0, Fall 0.
REQ-024 SHALL, if reset is asserted mid-count, lose the pending transition; a switch that is high at reset release is accepted after the normal DEBOUNCE_CYCLES+1 latency and produces one Rise.
REQ-025 SHALL deassert reset by synchronous release externally; the block performs no internal reset synchronization.

Structure
REQ-026 SHALL place the FSM state enumeration and the default DEBOUNCE_CYCLES/CNT_W constants in shared package led_ctrl_pkg.
REQ-027 SHALL instantiate the two-flop synchronizer as sub-module sync_2ff (async active-low reset, reset value 0), reusable by other switch inputs.
REQ-028 SHALL keep Enable, Rise and Fall driven directly from flops, with no combinational path from SW_raw.

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-029 SHALL cover a clean press: SW_raw 0->1 sampled at edge 0 and held -> Enable=1 and Rise=1 after edge 5; Rise=0 after edge 6.
REQ-030 SHALL cover glitch rejection: SW_raw high for 3 cycles then low -> Enable, Rise and Fall stay 0 throughout.
REQ-031 SHALL cover bounce: pattern 1,0,1,1,0,1 then held high -> exactly one Rise, 5 edges after the final 0->1 sample.
REQ-032 SHALL cover toggle mode (TOGGLE_MODE=1): three clean press/release cycles -> Enable sequence 1,0,1 with 3 Rise and 3 Fall pulses.
REQ-033 SHALL cover reset mid-count: rst_n low at count 2 with SW_raw held high, released -> outputs 0 during reset, then Rise after the full latency from the first post-reset sample.
REQ-034 SHALL cover DEBOUNCE_CYCLES=1: each held change -> outputs update at edge 2, with no WAIT state visited.
